// File: rtl/mem_read_arbiter_if.sv
// Bundle of the client-side request/response signals and the shared
// memory read port handled by mem_read_arbiter.
//
// Handshake semantics (one place, applies to every signal below):
//   - req[i] is a level request; it is accepted only while the arbiter is
//     idle. Once accepted, gnt[i] stays high until the transaction ends.
//   - The transaction ends with a one-cycle rd_valid[i] (rd_data valid in
//     that cycle and held afterwards) or a one-cycle rd_err[i] (timeout).
//     The requester drops req[i] in the cycle it sees either pulse.
//   - mem_read is a level strobe held with a stable mem_addr until the
//     memory raises data_ready (data_bus valid while data_ready is high)
//     or the timeout expires. data_ready must fall again before the next
//     read is issued.
interface mem_read_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt;
    logic [1:0]        rd_valid;
    logic [1:0]        rd_err;
    logic [DATA_W-1:0] rd_data;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic              data_ready;
    logic [DATA_W-1:0] data_bus;

    // Arbiter side.
    modport slave (
        input  req, addr0, addr1, data_ready, data_bus,
        output gnt, rd_valid, rd_err, rd_data, mem_read, mem_addr
    );

    // Environment side: the requesters plus the memory.
    modport master (
        output req, addr0, addr1, data_ready, data_bus,
        input  gnt, rd_valid, rd_err, rd_data, mem_read, mem_addr
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter between two read requesters sharing one level-handshake
// memory read port. Issues one read at a time, waits for data_ready (or a
// cycle timeout), returns the data to the granted requester, and waits for
// data_ready to fall before accepting the next request.
module mem_read_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16   // must be >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_read_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              last_q,     last_d;
    logic [1:0]        gnt_q,      gnt_d;
    logic [1:0]        rd_valid_q, rd_valid_d;
    logic [1:0]        rd_err_q,   rd_err_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 0 was served last.
    logic pick_one;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        rd_valid_d = 2'b00;
        rd_err_d   = 2'b00;
        rd_data_d  = rd_data_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        pick_one   = (bus.req == 2'b10) || ((bus.req == 2'b11) && !last_q);

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_d      = pick_one ? 2'b10 : 2'b01;
                    mem_addr_d = pick_one ? bus.addr1 : bus.addr0;
                    mem_read_d = 1'b1;
                    last_d     = pick_one;
                    cnt_d      = '0;
                    state_d    = S_READ;
                end
            end

            S_READ: begin
                // gnt_q is one-hot for the owner, so it doubles as the
                // response bit mask. Data wins over a coinciding timeout.
                if (bus.data_ready) begin
                    rd_data_d  = bus.data_bus;
                    rd_valid_d = gnt_q;
                    mem_read_d = 1'b0;
                    gnt_d      = 2'b00;
                    state_d    = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    rd_err_d   = gnt_q;
                    mem_read_d = 1'b0;
                    gnt_d      = 2'b00;
                    state_d    = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                // A ready still high from the last read must not complete
                // the next one, so hold off until it drops.
                if (!bus.data_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                gnt_d      = 2'b00;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            rd_valid_q <= 2'b00;
            rd_err_q   <= 2'b00;
            rd_data_q  <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.mem_read = mem_read_q;
    assign bus.mem_addr = mem_addr_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-requester controller for the shared level-handshake memory read port (`mem_read` / `data_ready` / `data_bus`). It arbitrates round-robin between requesters and drives `mem_read` and `mem_addr`. It waits for the `data_ready` level, captures `data_bus`, and returns the data to the granted requester. A cycle timeout prevents a stalled memory from hanging the bus. It sits between the client blocks and the memory read interface.

## Interface
- `DATA_W`, 8, width of `data_bus` / `rd_data`
- `ADDR_W`, 8, width of request and memory addresses
- `TIMEOUT`, 16, max cycles in READ without `data_ready` before error (>= 2)

- `clk` in 1 single clock, rising edge
- `rst` in 1 asynchronous, active-high reset
- `req` in 2 per-requester read request, level
- `addr0` in ADDR_W address of requester 0, sampled at grant
- `addr1` in ADDR_W address of requester 1, sampled at grant
- `gnt` out 2 one-hot; high from accept until completion
- `rd_valid` out 2 one-cycle pulse to the granted requester; `rd_data` valid
- `rd_err` out 2 one-cycle pulse on timeout
- `rd_data` out DATA_W captured read data, held until next capture
- `mem_read` out 1 memory read strobe, level
- `mem_addr` out ADDR_W memory address, held during transaction
- `data_ready` in 1 memory ready, level
- `data_bus` in DATA_W memory read data

## Operation
- All outputs are registered.
- Reset value of every output is 0. Internal state is reset to IDLE, the counter to 0, and `last` (last-served index) to 1, so requester 0 wins first.
- Reset is asynchronous. Asserting it mid-transaction drops `mem_read` and `gnt` immediately, with no `rd_valid` or `rd_err`.
- States: IDLE, READ, RELEASE.
- IDLE:
  - Only `req` with a bit set accepts.
  - If both bits are set, the requester != `last` wins.
  - On accept: `gnt[w]`<=1, `mem_addr`<=`addr_w`, `mem_read`<=1, `last`<=w, counter<=0, go to READ.
- READ:
  - `data_ready`=1: `rd_data`<=`data_bus`, `rd_valid[w]`<=1, `mem_read`<=0, `gnt`<=0, go to RELEASE.
  - Else, if counter==TIMEOUT-1: `rd_err[w]`<=1, `mem_read`<=0, `gnt`<=0, `rd_data` unchanged, go to RELEASE.
  - Else counter+1.
  - If `data_ready` and timeout coincide, data wins.
- RELEASE: wait for `data_ready`==0, then go to IDLE. No new grant is issued while `data_ready` is still high, which prevents a stale ready from completing the next read.
- `req` changes after accept are ignored; the transaction always completes or times out.
- A requester must drop `req` in the cycle `rd_valid` or `rd_err` is seen. A `req` still high in IDLE is a new request.
- Counter width is clog2(TIMEOUT); it never wraps, because it stops at TIMEOUT-1.

## Timing
- Edge k samples `req` in IDLE → `mem_read`, `gnt`, `mem_addr` high/valid after edge k.
- First edge with `data_ready`=1 in READ (k+1 at earliest) → `rd_valid` and `rd_data` after that edge. Minimum request-to-data latency is 2 cycles.
- RELEASE lasts at least 1 cycle. With `data_ready` low at the first RELEASE edge, IDLE is reached and the next grant follows one edge later. Minimum back-to-back spacing is 3 cycles between `mem_read` rises.
- Timeout: `rd_err` asserts TIMEOUT cycles after `mem_read` rises if `data_ready` never asserts.
- `rd_valid` and `rd_err` are never high together, are never high for 2 cycles, and only the bit of the granted requester is ever set.

## Test plan
- Reset, then `req`=01, `addr0`=8'h10, memory returns 8'hDE with `data_ready` 2 cycles later → `mem_addr`=8'h10; `rd_valid`=01 with `rd_data`=8'hDE; `gnt` falls in the same cycle.
- `req`=11 held, both complete immediately → grants alternate 01,10,01,10; data 8'hDE/8'hAD routed to the correct `rd_valid` bit.
- `data_ready` never asserts, TIMEOUT=16 → `rd_err`=01 exactly 16 cycles after `mem_read` rise; `mem_read`=0; `rd_data` keeps its previous value.
- `data_ready` held high 5 cycles after capture with `req`=10 pending → no grant until `data_ready` falls; then 1 IDLE cycle; then `gnt`=10.
- `data_ready` asserted exactly at counter==TIMEOUT-1 → `rd_valid` asserts, `rd_err` stays 0.
- `rst` pulsed while in READ → `mem_read`, `gnt`, `rd_valid`, `rd_err` go to 0 asynchronously; after release, `req`=11 grants requester 0 first.
